burst_gate_gen: RTL and testbench
=================================

Name: burst_gate_gen

Overview:
- Generates the per-line colour-burst window for the chroma PLL from raw composite samples.
- Detects and qualifies horizontal sync tips, then asserts burst_active for a fixed window after each qualified sync trailing edge.
- Measures the line period and flags line lock.
- Sits between the ADC sample stream and the burst-averaging loop filter. burst_active drives that filter's accumulate window.

Parameters:
- SYNC_THRESH, -512: signed 12-bit level; video_in < SYNC_THRESH means the sample is in a sync tip.
- MIN_SYNC, 40: minimum sync-tip length in clocks for a qualified hsync.
- MAX_SYNC, 100: maximum sync-tip length; longer tips (broad/vsync pulses) are rejected.
- BURST_DELAY, 9: clocks from hsync_pulse to the first burst_active clock; range 1..255.
- BURST_LEN, 36: burst_active width in clocks; range 1..127.
- NOMINAL_LINE, 910: expected clocks per line.
- LINE_TOL, 8: allowed deviation of a measured period from NOMINAL_LINE, in clocks.
- LOCK_COUNT, 4: lock-counter value at which line_locked sets.
- GATE_ON_LOCK, 0: if 1, a burst window is generated only while line_locked=1.

Ports:
- clk, input, 1: sample clock.
- rst, input, 1: asynchronous active-high reset.
- video_in, input, 12: signed composite sample, one per clk.
- hsync_pulse, output, 1: one-clock strobe on each qualified hsync.
- burst_active, output, 1: colour-burst window.
- line_period, output, 14: clocks between the last two qualified hsyncs; saturating.
- line_locked, output, 1: line timing stable.

Behaviour:
- All outputs are registered.
- Reset clears every output to 0 and puts the FSM in IDLE. Reset also clears sync_cnt, dly_cnt, burst_cnt, line_cnt, good_cnt and first_seen.
- Reset asserted mid-burst drops burst_active to 0 immediately (asynchronous).
- FSM states: IDLE, IN_SYNC, DELAY, BURST.
- IDLE:
  - video_in < SYNC_THRESH -> IN_SYNC with sync_cnt=1.
- IN_SYNC:
  - While video_in stays below SYNC_THRESH, sync_cnt increments, saturating at MAX_SYNC+1.
  - On the first sample >= SYNC_THRESH (edge clock T), if MIN_SYNC <= sync_cnt <= MAX_SYNC: qualified. hsync_pulse=1 in clock T+1 and the FSM goes to DELAY.
  - Otherwise -> IDLE with no pulse. This rejects glitches, equalizing pulses and broad pulses.
- DELAY:
  - video_in is ignored.
  - burst_active=1 starts in clock T+1+BURST_DELAY, then the FSM goes to BURST.
  - With GATE_ON_LOCK=1 and line_locked=0 (value after this hsync's lock update), the FSM returns to IDLE with no burst.
- BURST:
  - video_in is ignored.
  - burst_active stays high exactly BURST_LEN consecutive clocks, then the FSM goes to IDLE.
  - A sync tip during DELAY or BURST is not seen. Detection resumes in IDLE.
- line_cnt (14-bit):
  - Increments every clock and saturates at 16383.
  - On each qualified hsync, line_period <= line_cnt and line_cnt <= 1.
- Lock counter (good_cnt, evaluated on each qualified hsync):
  - The first qualified hsync after reset only sets first_seen and does not evaluate the period.
  - Afterwards: if |line_cnt - NOMINAL_LINE| <= LINE_TOL, good_cnt increments, saturating at LOCK_COUNT.
  - Otherwise good_cnt decrements, floored at 0.
- line_locked:
  - Sets when good_cnt reaches LOCK_COUNT.
  - Clears when good_cnt reaches 0 (hysteresis), or when line_cnt saturates (16383).
  - On saturation, good_cnt is also cleared.
- Arithmetic:
  - The period comparison uses unsigned 15-bit subtraction with an explicit absolute value.
  - All counters are sized to their parameter maxima and never wrap.

Test Plan:
- Clean lines: sync tip 67 clk at -1000, period 910, 20 lines. Required: hsync_pulse 1 clk after each trailing edge; burst_active 36 clk wide starting 9 clk after each hsync_pulse; line_period=910; line_locked rises on the 5th hsync (4th evaluated period).
- Sync widths 39, 40, 100, 101 clk. Required: hsync_pulse only for the 40 and 100 clk tips; no burst for the 39 and 101 clk tips.
- Locked stream, then one period of 930 followed by 910 periods. Required: good_cnt drops to 3 then returns to 4; line_locked stays 1 throughout.
- Locked stream, then video held at 0 for 16383+ clk. Required: line_locked falls on the clock line_cnt saturates; the next hsync reports line_period=16383.
- GATE_ON_LOCK=1, clean lines from reset. Required: no burst_active for the first 4 hsyncs; burst on the 5th hsync and every hsync after.
- rst pulsed mid-burst (clock 10 of 36). Required: burst_active=0 asynchronously, all outputs 0; the next valid sync is qualified normally.

Source files
------------

// File: rtl/burst_gate_gen.sv
// burst_gate_gen: qualifies horizontal sync tips in the raw composite sample
// stream, opens a fixed colour-burst window after each qualified sync, and
// tracks line period / line lock for the chroma PLL front end.
module burst_gate_gen #(
    parameter logic signed [11:0] SYNC_THRESH  = -12'sd512,
    parameter int                 MIN_SYNC     = 40,
    parameter int                 MAX_SYNC     = 100,
    parameter int                 BURST_DELAY  = 9,
    parameter int                 BURST_LEN    = 36,
    parameter int                 NOMINAL_LINE = 910,
    parameter int                 LINE_TOL     = 8,
    parameter int                 LOCK_COUNT   = 4,
    parameter bit                 GATE_ON_LOCK = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [11:0] video_in,
    output logic               hsync_pulse,
    output logic               burst_active,
    output logic [13:0]        line_period,
    output logic               line_locked
);

    // Counter widths sized to the largest value each one has to hold.
    localparam int SYNC_W = $clog2(MAX_SYNC + 2);
    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);

    localparam logic [SYNC_W-1:0] SYNC_ONE  = SYNC_W'(1);
    localparam logic [SYNC_W-1:0] SYNC_MIN  = SYNC_W'(MIN_SYNC);
    localparam logic [SYNC_W-1:0] SYNC_MAX  = SYNC_W'(MAX_SYNC);
    localparam logic [SYNC_W-1:0] SYNC_SAT  = SYNC_W'(MAX_SYNC + 1);
    localparam logic [7:0]        DLY_LAST  = 8'(BURST_DELAY);
    localparam logic [6:0]        BURST_END = 7'(BURST_LEN);
    localparam logic [13:0]       LINE_MAX  = 14'h3FFF;
    localparam logic [14:0]       NOM15     = 15'(NOMINAL_LINE);
    localparam logic [14:0]       TOL15     = 15'(LINE_TOL);
    localparam logic [GOOD_W-1:0] GOOD_ONE  = GOOD_W'(1);
    localparam logic [GOOD_W-1:0] GOOD_FULL = GOOD_W'(LOCK_COUNT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IN_SYNC = 2'd1,
        DELAY   = 2'd2,
        BURST   = 2'd3
    } state_t;

    state_t             state_q,      state_d;
    logic [SYNC_W-1:0]  sync_cnt_q,   sync_cnt_d;
    logic [7:0]         dly_cnt_q,    dly_cnt_d;
    logic [6:0]         burst_cnt_q,  burst_cnt_d;
    logic [13:0]        line_cnt_q,   line_cnt_d;
    logic [GOOD_W-1:0]  good_cnt_q,   good_cnt_d;
    logic               first_seen_q, first_seen_d;
    logic               hsync_q,      hsync_d;
    logic               burst_q,      burst_d;
    logic [13:0]        period_q,     period_d;
    logic               locked_q,     locked_d;

    logic               in_tip;
    logic               qual;
    logic [14:0]        period_diff;
    logic [14:0]        period_abs;
    logic               period_ok;

    assign in_tip = (video_in < SYNC_THRESH);

    // Deviation from nominal: unsigned 15-bit difference, then fold negatives.
    assign period_diff = {1'b0, line_cnt_q} - NOM15;
    assign period_abs  = period_diff[14] ? (15'd0 - period_diff) : period_diff;
    assign period_ok   = (period_abs <= TOL15);

    // State and output registers; reset drops everything, burst window included.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            sync_cnt_q   <= '0;
            dly_cnt_q    <= '0;
            burst_cnt_q  <= '0;
            line_cnt_q   <= '0;
            good_cnt_q   <= '0;
            first_seen_q <= 1'b0;
            hsync_q      <= 1'b0;
            burst_q      <= 1'b0;
            period_q     <= '0;
            locked_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_cnt_q   <= sync_cnt_d;
            dly_cnt_q    <= dly_cnt_d;
            burst_cnt_q  <= burst_cnt_d;
            line_cnt_q   <= line_cnt_d;
            good_cnt_q   <= good_cnt_d;
            first_seen_q <= first_seen_d;
            hsync_q      <= hsync_d;
            burst_q      <= burst_d;
            period_q     <= period_d;
            locked_q     <= locked_d;
        end
    end

    // Next state: sync qualification, burst window timing, period and lock tracking.
    always_comb begin
        state_d      = state_q;
        sync_cnt_d   = sync_cnt_q;
        dly_cnt_d    = dly_cnt_q;
        burst_cnt_d  = burst_cnt_q;
        line_cnt_d   = line_cnt_q;
        good_cnt_d   = good_cnt_q;
        first_seen_d = first_seen_q;
        hsync_d      = 1'b0;
        burst_d      = burst_q;
        period_d     = period_q;
        locked_d     = locked_q;
        qual         = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_tip) begin
                    state_d    = IN_SYNC;
                    sync_cnt_d = SYNC_ONE;
                end
            end
            IN_SYNC: begin
                if (in_tip) begin
                    // Saturate one past the max so broad pulses stay rejected.
                    if (sync_cnt_q != SYNC_SAT)
                        sync_cnt_d = sync_cnt_q + SYNC_ONE;
                end else begin
                    sync_cnt_d = '0;
                    if ((sync_cnt_q >= SYNC_MIN) && (sync_cnt_q <= SYNC_MAX)) begin
                        qual      = 1'b1;
                        state_d   = DELAY;
                        dly_cnt_d = 8'd1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DELAY: begin
                // Lock flag already reflects this hsync's update here.
                if (GATE_ON_LOCK && !locked_q) begin
                    state_d = IDLE;
                end else if (dly_cnt_q == DLY_LAST) begin
                    burst_d     = 1'b1;
                    burst_cnt_d = 7'd1;
                    state_d     = BURST;
                end else begin
                    dly_cnt_d = dly_cnt_q + 8'd1;
                end
            end
            BURST: begin
                if (burst_cnt_q == BURST_END) begin
                    burst_d = 1'b0;
                    state_d = IDLE;
                end else begin
                    burst_cnt_d = burst_cnt_q + 7'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (qual) begin
            hsync_d    = 1'b1;
            period_d   = line_cnt_q;
            line_cnt_d = 14'd1;
            if (!first_seen_q) begin
                // First sync after reset has no valid period to judge.
                first_seen_d = 1'b1;
            end else begin
                if (period_ok) begin
                    if (good_cnt_q != GOOD_FULL)
                        good_cnt_d = good_cnt_q + GOOD_ONE;
                end else begin
                    if (good_cnt_q != '0)
                        good_cnt_d = good_cnt_q - GOOD_ONE;
                end
                // Hysteresis: set only at full count, clear only at empty.
                if (good_cnt_d == GOOD_FULL)
                    locked_d = 1'b1;
                else if (good_cnt_d == '0)
                    locked_d = 1'b0;
            end
        end else begin
            if (line_cnt_q != LINE_MAX)
                line_cnt_d = line_cnt_q + 14'd1;
            // Lost syncs entirely: drop lock the moment the counter pegs.
            if (line_cnt_d == LINE_MAX) begin
                good_cnt_d = '0;
                locked_d   = 1'b0;
            end
        end
    end

    assign hsync_pulse  = hsync_q;
    assign burst_active = burst_q;
    assign line_period  = period_q;
    assign line_locked  = locked_q;

endmodule

// File: tb/tb_burst_gate_gen.sv
// Bench for burst_gate_gen: an ungated and a lock-gated instance share one
// sample stream; both are compared every clock against a timestamp-based model.
module tb_burst_gate_gen;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [11:0] video;
    logic               hs0, b0, lk0, hs1, b1, lk1;
    logic [13:0]        lp0, lp1;

    always #5 clk = ~clk;

    burst_gate_gen u_d0 (
        .clk(clk), .rst(rst), .video_in(video),
        .hsync_pulse(hs0), .burst_active(b0), .line_period(lp0), .line_locked(lk0)
    );

    burst_gate_gen #(.GATE_ON_LOCK(1'b1)) u_d1 (
        .clk(clk), .rst(rst), .video_in(video),
        .hsync_pulse(hs1), .burst_active(b1), .line_period(lp1), .line_locked(lk1)
    );

    int checks = 0;
    int errors = 0;
    int n = 0;

    // Model: absolute clock stamps for blind interval and burst window.
    int m_run[2], m_resume[2], m_bs[2], m_be[2], m_lc[2], m_good[2], m_per[2];
    bit m_lock[2], m_first[2], m_hs[2];

    // Monitor of the ungated instance.
    int hs_cnt = 0, hs_cyc = 0, b_run = 0, bursts0 = 0, bursts1 = 0;
    int last_per = 0, lock_rise_hs = -1;
    bit prev_b0 = 0, prev_b1 = 0, prev_lk0 = 0;

    typedef struct {
        int w;
        int lvl;
        int exp_hs;
    } vec_t;
    vec_t tbl[9];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (clk %0d)", name, act, exp, n);
        end
    endtask

    task automatic mreset(input int g);
        m_run[g] = 0; m_resume[g] = 0; m_bs[g] = -1; m_be[g] = -1;
        m_lc[g] = 0; m_good[g] = 0; m_per[g] = 0;
        m_lock[g] = 0; m_first[g] = 0; m_hs[g] = 0;
    endtask

    task automatic mstep(input int g, input logic signed [11:0] v, input bit gate);
        bit q;
        int d;
        q = 0;
        m_hs[g] = 0;
        if (n >= m_resume[g]) begin
            if (v < -512) begin
                if (m_run[g] < 101) m_run[g]++;
            end else begin
                if (m_run[g] >= 40 && m_run[g] <= 100) q = 1;
                m_run[g] = 0;
            end
        end
        if (q) begin
            m_per[g] = m_lc[g];
            if (!m_first[g]) m_first[g] = 1;
            else begin
                d = m_lc[g] - 910;
                if (d < 0) d = -d;
                if (d <= 8) begin if (m_good[g] < 4) m_good[g]++; end
                else begin if (m_good[g] > 0) m_good[g]--; end
                if (m_good[g] == 4) m_lock[g] = 1;
                else if (m_good[g] == 0) m_lock[g] = 0;
            end
            m_lc[g] = 1;
            m_hs[g] = 1;
            if (gate && !m_lock[g]) begin
                m_resume[g] = n + 2;
            end else begin
                m_bs[g] = n + 9;
                m_be[g] = n + 9 + 36;
                m_resume[g] = n + 9 + 36 + 1;
            end
        end else begin
            if (m_lc[g] < 16383) m_lc[g]++;
            if (m_lc[g] == 16383) begin m_good[g] = 0; m_lock[g] = 0; end
        end
    endtask

    task automatic mcmp(input string name, input logic [16:0] act, input logic [16:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got hs/burst/period/lock %h expected %h (clk %0d)", name, act, exp, n);
        end
    endtask

    // One sample: drive, clock, advance model, compare after the edge.
    task automatic tick(input logic signed [11:0] v);
        bit eb;
        video = v;
        @(posedge clk);
        n++;
        for (int g = 0; g < 2; g++) begin
            if (rst) mreset(g);
            else mstep(g, v, g == 1);
        end
        #1;
        for (int g = 0; g < 2; g++) begin
            eb = (n >= m_bs[g]) && (n < m_be[g]);
            if (g == 0) mcmp("model_d0", {hs0, b0, lp0, lk0}, {m_hs[0], eb, 14'(m_per[0]), m_lock[0]});
            else        mcmp("model_d1", {hs1, b1, lp1, lk1}, {m_hs[1], eb, 14'(m_per[1]), m_lock[1]});
        end
        if (!rst) begin
            if (hs0) begin hs_cnt++; hs_cyc = n; last_per = int'(lp0); end
            if (b0 && !prev_b0) begin
                chk("burst_offset", n - hs_cyc, 9);
                bursts0++;
                b_run = 1;
            end else if (b0) b_run++;
            if (!b0 && prev_b0) chk("burst_width", b_run, 36);
            if (b1 && !prev_b1) bursts1++;
            if (lk0 && !prev_lk0 && lock_rise_hs < 0) lock_rise_hs = hs_cnt;
            prev_b0 = b0; prev_b1 = b1; prev_lk0 = lk0;
        end
    endtask

    task automatic line(input int w, input int per, input int lvl);
        for (int i = 0; i < w; i++) tick(12'(lvl));
        for (int i = w; i < per; i++) tick(12'sd0);
    endtask

    initial begin
        int h0, bb0, w, per, lvl;
        bit fell, hit;

        tbl[0] = '{39, -1000, 0};
        tbl[1] = '{40, -1000, 1};
        tbl[2] = '{100, -1000, 1};
        tbl[3] = '{101, -1000, 0};
        tbl[4] = '{5, -1000, 0};
        tbl[5] = '{67, -1000, 1};
        tbl[6] = '{200, -2048, 0};
        tbl[7] = '{67, -512, 0};
        tbl[8] = '{67, -513, 1};

        rst = 1'b1;
        video = 12'sd0;
        for (int g = 0; g < 2; g++) mreset(g);
        repeat (3) tick(12'sd0);
        rst = 1'b0;
        chk("rst_hsync", int'(hs0), 0);
        chk("rst_burst", int'(b0), 0);
        chk("rst_period", int'(lp0), 0);
        chk("rst_locked", int'(lk0), 0);
        chk("rst_burst_gated", int'(b1), 0);

        // Clean lines from reset.
        repeat (20) tick(12'sd0);
        for (int i = 0; i < 20; i++) line(67, 910, -1000);
        chk("clean_hsyncs", hs_cnt, 20);
        chk("clean_bursts", bursts0, 20);
        chk("clean_period", last_per, 910);
        chk("lock_on_hsync", lock_rise_hs, 5);
        chk("gated_bursts", bursts1, 16);
        chk("clean_locked", int'(lk0), 1);

        // Sync width / level table.
        for (int i = 0; i < 9; i++) begin
            h0 = hs_cnt; bb0 = bursts0;
            line(tbl[i].w, 910, tbl[i].lvl);
            chk($sformatf("tbl%0d_hsync", i), hs_cnt - h0, tbl[i].exp_hs);
            chk($sformatf("tbl%0d_burst", i), bursts0 - bb0, tbl[i].exp_hs);
        end

        // One long period while locked.
        for (int i = 0; i < 6; i++) line(67, 910, -1000);
        chk("relock", int'(lk0), 1);
        chk("good_full", int'(u_d0.good_cnt_q), 4);
        line(67, 930, -1000);
        line(67, 910, -1000);
        chk("per_930", last_per, 930);
        chk("good_dip", int'(u_d0.good_cnt_q), 3);
        chk("lock_held_dip", int'(lk0), 1);
        line(67, 910, -1000);
        chk("good_back", int'(u_d0.good_cnt_q), 4);
        chk("lock_held_back", int'(lk0), 1);

        // Random lines with noisy porches.
        for (int i = 0; i < 15; i++) begin
            w = $urandom_range(110, 30);
            per = $urandom_range(940, 880);
            for (int k = 0; k < w; k++) begin
                lvl = -513 - int'($urandom_range(1535, 0));
                tick(12'(lvl));
            end
            for (int k = w; k < per; k++) begin
                if ($urandom_range(99, 0) == 0) lvl = -513 - int'($urandom_range(100, 0));
                else lvl = int'($urandom_range(1510, 0)) - 511;
                tick(12'(lvl));
            end
        end

        // Lose sync until the line counter pegs.
        for (int i = 0; i < 6; i++) line(67, 910, -1000);
        chk("sat_prelock", int'(lk0), 1);
        fell = 0;
        for (int i = 0; i < 16500; i++) begin
            tick(12'sd0);
            if (!fell && !lk0) begin
                fell = 1;
                chk("sat_cnt_at_unlock", int'(u_d0.line_cnt_q), 16383);
            end
        end
        chk("sat_unlocked", int'(fell), 1);
        line(67, 910, -1000);
        chk("sat_period", last_per, 16383);

        // Reset in the middle of a burst.
        for (int i = 0; i < 67; i++) tick(-12'sd1000);
        hit = 0;
        for (int i = 0; i < 60 && !hit; i++) begin
            tick(12'sd0);
            if (b0 && b_run == 10) hit = 1;
        end
        chk("midburst_reached", int'(hit), 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_burst", int'(b0), 0);
        chk("arst_hsync", int'(hs0), 0);
        chk("arst_period", int'(lp0), 0);
        chk("arst_locked", int'(lk0), 0);
        chk("arst_period_gated", int'(lp1), 0);
        prev_b0 = 0; prev_b1 = 0; prev_lk0 = 0; b_run = 0;
        repeat (2) tick(12'sd0);
        rst = 1'b0;
        h0 = hs_cnt; bb0 = bursts0;
        repeat (10) tick(12'sd0);
        line(67, 910, -1000);
        chk("post_rst_hsync", hs_cnt - h0, 1);
        chk("post_rst_burst", bursts0 - bb0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
